// File: rtl/sccb_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_config_sequencer
// Description : Walks the camera register table and writes each
//               {register, value} entry over SCCB as a 3-phase write.
//               Build option SCCB_ACK_CHECK_EN adds siod_in/nack for 9th-bit
//               checking.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_config_sequencer #(
    parameter int         QTR_CYCLES        = 62,
    parameter logic [7:0] DEV_ADDR          = 8'h42,
    parameter int         GAP_CYCLES        = 256,
    parameter int         RESET_WAIT_CYCLES = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] control,
    input  logic        finished,
`ifdef SCCB_ACK_CHECK_EN
    input  logic        siod_in,
    output logic        nack,
`endif
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_oe,
    output logic        busy,
    output logic        config_done
);

    localparam int c_max_qg   = (QTR_CYCLES > GAP_CYCLES) ? QTR_CYCLES : GAP_CYCLES;
    localparam int c_max_cyc  = (c_max_qg > RESET_WAIT_CYCLES) ? c_max_qg : RESET_WAIT_CYCLES;
    localparam int c_cw       = $clog2(c_max_cyc + 1);

    localparam logic [c_cw-1:0] c_qtr_last   = c_cw'(QTR_CYCLES - 1);
    localparam logic [c_cw-1:0] c_gap_last   = c_cw'(GAP_CYCLES - 1);
    localparam logic [c_cw-1:0] c_rwait_last = c_cw'(RESET_WAIT_CYCLES - 1);
    localparam logic [c_cw-1:0] c_fetch_last = c_cw'(1);

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_rewind = 4'd1;
    localparam logic [3:0] c_st_fetch  = 4'd2;
    localparam logic [3:0] c_st_check  = 4'd3;
    localparam logic [3:0] c_st_start  = 4'd4;
    localparam logic [3:0] c_st_bits   = 4'd5;
    localparam logic [3:0] c_st_stop   = 4'd6;
    localparam logic [3:0] c_st_gap    = 4'd7;
    localparam logic [3:0] c_st_done   = 4'd8;

    logic [3:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [1:0]      r_qtr;
    logic [3:0]      r_bitpos;
    logic [1:0]      r_byte;
    logic [23:0]     r_shift;
    logic            r_is_reset;
    logic            r_resend;
    logic            r_advance;
    logic            r_sioc;
    logic            r_siod_oe;
    logic            r_busy;
    logic            r_done;

    logic            w_qtr_end;
    logic [c_cw-1:0] w_gap_last;

    assign w_qtr_end  = (r_cnt == c_qtr_last);
    assign w_gap_last = r_is_reset ? c_rwait_last : c_gap_last;

`ifdef SCCB_ACK_CHECK_EN
    logic r_nack;
    logic r_nack_pend;
    assign nack = r_nack;
`endif

    assign resend      = r_resend;
    assign advance     = r_advance;
    assign sioc        = r_sioc;
    assign siod_oe     = r_siod_oe;
    assign busy        = r_busy;
    assign config_done = r_done;

    // Outputs for each quarter are loaded on the edge that enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_qtr      <= '0;
            r_bitpos   <= '0;
            r_byte     <= '0;
            r_shift    <= '0;
            r_is_reset <= 1'b0;
            r_resend   <= 1'b0;
            r_advance  <= 1'b0;
            r_sioc     <= 1'b1;
            r_siod_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            r_nack      <= 1'b0;
            r_nack_pend <= 1'b0;
`endif
        end else begin
            r_resend  <= 1'b0;
            r_advance <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state  <= c_st_rewind;
                        r_resend <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                        r_nack   <= 1'b0;
`endif
                    end
                end
                c_st_rewind: begin
                    r_state <= c_st_fetch;
                    r_cnt   <= '0;
                end
                c_st_fetch: begin
                    if (r_cnt == c_fetch_last) begin
                        r_state <= c_st_check;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_check: begin
                    if (finished) begin
                        r_state <= c_st_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= c_st_start;
                        r_shift    <= {DEV_ADDR, control};
                        r_is_reset <= (control == 16'h1280);
                        r_cnt      <= '0;
                        r_qtr      <= '0;
                        r_bitpos   <= '0;
                        r_byte     <= '0;
                        r_sioc     <= 1'b1;
                        r_siod_oe  <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                        r_nack_pend <= 1'b0;
`endif
                    end
                end
                c_st_start: begin
                    if (w_qtr_end) begin
                        r_cnt <= '0;
                        if (r_qtr == 2'd0) begin
                            r_qtr  <= 2'd1;
                            r_sioc <= 1'b0;
                        end else begin
                            r_qtr     <= 2'd0;
                            r_state   <= c_st_bits;
                            r_siod_oe <= ~r_shift[23];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_bits: begin
                    if (w_qtr_end) begin
                        r_cnt <= '0;
                        r_qtr <= r_qtr + 2'd1;
                        case (r_qtr)
                            2'd0: r_sioc <= 1'b1;
                            2'd1: r_sioc <= 1'b1;
                            2'd2: begin
                                r_sioc <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
                                if (r_bitpos == 4'd8 && siod_in)
                                    r_nack_pend <= 1'b1;
`endif
                            end
                            default: begin
                                // bitpos 8 is the released 9th bit of the byte
                                if (r_bitpos == 4'd8) begin
                                    if (r_byte == 2'd2) begin
                                        r_state   <= c_st_stop;
                                        r_siod_oe <= 1'b1;
                                    end else begin
                                        r_bitpos  <= '0;
                                        r_byte    <= r_byte + 2'd1;
                                        r_siod_oe <= ~r_shift[23];
                                    end
                                end else begin
                                    r_shift   <= {r_shift[22:0], 1'b0};
                                    r_bitpos  <= r_bitpos + 4'd1;
                                    r_siod_oe <= (r_bitpos == 4'd7) ? 1'b0 : ~r_shift[22];
                                end
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    if (w_qtr_end) begin
                        r_cnt <= '0;
                        case (r_qtr)
                            2'd0: begin
                                r_qtr  <= 2'd1;
                                r_sioc <= 1'b1;
                            end
                            2'd1: begin
                                r_qtr     <= 2'd2;
                                r_siod_oe <= 1'b0;
                            end
                            default: begin
                                r_qtr <= 2'd0;
`ifdef SCCB_ACK_CHECK_EN
                                if (r_nack_pend) begin
                                    r_state <= c_st_done;
                                    r_nack  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state   <= c_st_gap;
                                    r_advance <= 1'b1;
                                end
`else
                                r_state   <= c_st_gap;
                                r_advance <= 1'b1;
`endif
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_gap: begin
                    if (r_cnt == w_gap_last) begin
                        r_state <= c_st_fetch;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
